// File: rtl/seg_display_mux.sv
// ============================================================================
// Module      : seg_display_mux
// Description : Time-multiplexes four BCD digits onto a 4-digit common-anode
//               seven-segment display, with field blinking in adjust mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_mux #(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adj,
    input  logic       sel,
    input  logic [3:0] min_ten,
    input  logic [3:0] min_one,
    input  logic [3:0] sec_ten,
    input  logic [3:0] sec_one,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);

    logic [c_REF_W-1:0] r_refresh_cnt;
    logic [1:0]         r_idx;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [3:0]         r_sh_min_ten, r_sh_min_one, r_sh_sec_ten, r_sh_sec_one;
    logic [7:0]         r_seg;
    logic [3:0]         r_an;

    logic               w_slot_end;
    logic               w_frame_end;
    logic [3:0]         w_digit;
    logic [3:0]         w_an_next;
    logic [7:0]         w_dec;
    logic               w_in_field;
    logic               w_blank;

    assign w_slot_end  = (r_refresh_cnt == c_REF_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh_cnt <= '0;
            r_idx         <= 2'd0;
        end else if (w_slot_end) begin
            r_refresh_cnt <= '0;
            r_idx         <= r_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // All four digits are captured at once so a frame never mixes two counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_min_ten <= 4'd0;
            r_sh_min_one <= 4'd0;
            r_sh_sec_ten <= 4'd0;
            r_sh_sec_one <= 4'd0;
        end else if (w_frame_end) begin
            r_sh_min_ten <= min_ten;
            r_sh_min_one <= min_one;
            r_sh_sec_ten <= sec_ten;
            r_sh_sec_one <= sec_one;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!adj) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_BLK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        w_digit   = r_sh_sec_one;
        w_an_next = 4'b1110;
        case (r_idx)
            2'd0: begin w_digit = r_sh_sec_one; w_an_next = 4'b1110; end
            2'd1: begin w_digit = r_sh_sec_ten; w_an_next = 4'b1101; end
            2'd2: begin w_digit = r_sh_min_one; w_an_next = 4'b1011; end
            2'd3: begin w_digit = r_sh_min_ten; w_an_next = 4'b0111; end
            default: begin w_digit = r_sh_sec_one; w_an_next = 4'b1110; end
        endcase
    end

    always_comb begin
        w_dec = 8'hBF;
        case (w_digit)
            4'd0: w_dec = 8'hC0;
            4'd1: w_dec = 8'hF9;
            4'd2: w_dec = 8'hA4;
            4'd3: w_dec = 8'hB0;
            4'd4: w_dec = 8'h99;
            4'd5: w_dec = 8'h92;
            4'd6: w_dec = 8'h82;
            4'd7: w_dec = 8'hF8;
            4'd8: w_dec = 8'h80;
            4'd9: w_dec = 8'h90;
            default: w_dec = 8'hBF;
        endcase
    end

    // adj is used live so dropping it un-blanks on the very next edge.
    assign w_in_field = sel ? (r_idx[1] == 1'b0) : (r_idx[1] == 1'b1);
    assign w_blank    = adj && r_blink_phase && w_in_field;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= 8'hFF;
            r_an  <= 4'b1111;
        end else begin
            r_seg <= w_blank ? 8'hFF : w_dec;
            r_an  <= w_an_next;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_mux.sv
// ============================================================================
// Module      : tb_seg_display_mux
// Description : Scoreboard bench for seg_display_mux with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_ten = 4'd0;
    logic [3:0] min_one = 4'd0;
    logic [3:0] sec_ten = 4'd0;
    logic [3:0] sec_one = 4'd0;
    logic [7:0] seg;
    logic [3:0] an;

    int n_vec = 0;
    int n_err = 0;
    int n_slot = 0;
    logic [11:0] exp_q [$];
    logic [3:0]  c_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .adj     (adj),
        .sel     (sel),
        .min_ten (min_ten),
        .min_one (min_one),
        .sec_ten (sec_ten),
        .sec_one (sec_one),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one registered output per clock, compared against the oldest expectation.
    always begin
        logic [11:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_slot++;
            check($sformatf("slot%0d {an,seg}", n_slot), {20'd0, an, seg}, {20'd0, e});
        end
    end

    // Called at a negedge with inputs already set for the coming edge.
    task automatic step(input logic [3:0] a, input logic [7:0] s);
        exp_q.push_back({a, s});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_slot(input int slot, input logic [7:0] s);
        for (int i = 0; i < 4; i++) step(c_an[slot], s);
    endtask

    task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
        run_slot(0, s0);
        run_slot(1, s1);
        run_slot(2, s2);
        run_slot(3, s3);
    endtask

    initial begin
        #3 rst = 1'b0;
        min_ten = 4'd1; min_one = 4'd2; sec_ten = 4'd3; sec_one = 4'd4;
        repeat (3) @(negedge clk);
        check("reset an", {28'd0, an}, 32'h0000000F);
        check("reset seg", {24'd0, seg}, 32'h000000FF);

        // First frame shows the zeroed shadows, second the snapshot 12:34.
        rst = 1'b1;
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        run_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);

        // sec_one changes mid-frame; only the frame after the snapshot shows 5.
        run_slot(0, 8'h99);
        sec_one = 4'd5;
        run_slot(1, 8'hB0);
        run_slot(2, 8'hA4);
        run_slot(3, 8'hF9);
        run_frame(8'h92, 8'hB0, 8'hA4, 8'hF9);

        // Blink seconds, entered half a frame in so the blank phase lands on slots 0,1.
        run_slot(0, 8'h92);
        run_slot(1, 8'hB0);
        adj = 1'b1; sel = 1'b1;
        run_slot(2, 8'hA4);
        run_slot(3, 8'hF9);
        run_frame(8'hFF, 8'hFF, 8'hA4, 8'hF9);

        // Drop adj while blanked: digit returns on the next edge, blink state clears.
        run_slot(0, 8'hFF);
        adj = 1'b0;
        step(4'b1101, 8'hB0);
        check("blink_cnt after adj drop", 32'(dut.r_blink_cnt), 32'd0);
        check("blink_phase after adj drop", {31'd0, dut.r_blink_phase}, 32'd0);
        for (int i = 0; i < 3; i++) step(4'b1101, 8'hB0);
        run_slot(2, 8'hA4);
        run_slot(3, 8'hF9);

        // Blink minutes from a frame boundary; then switch sel mid-blank.
        adj = 1'b1; sel = 1'b0;
        run_frame(8'h92, 8'hB0, 8'hFF, 8'hFF);
        run_slot(0, 8'h92);
        run_slot(1, 8'hB0);
        run_slot(2, 8'hFF);
        sel = 1'b1;
        run_slot(3, 8'hF9);

        // Out-of-range BCD shows a dash.
        adj = 1'b0;
        sec_ten = 4'hC;
        run_frame(8'h92, 8'hB0, 8'hA4, 8'hF9);
        run_frame(8'h92, 8'hBF, 8'hA4, 8'hF9);

        // Async reset mid slot 2.
        run_slot(0, 8'h92);
        run_slot(1, 8'hBF);
        step(4'b1011, 8'hA4);
        step(4'b1011, 8'hA4);
        rst = 1'b0;
        #1;
        check("async reset an", {28'd0, an}, 32'h0000000F);
        check("async reset seg", {24'd0, seg}, 32'h000000FF);
        @(negedge clk);
        check("held reset an", {28'd0, an}, 32'h0000000F);
        @(negedge clk);

        // Free-run three frames after release.
        rst = 1'b1;
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        run_frame(8'h92, 8'hBF, 8'hA4, 8'hF9);
        run_frame(8'h92, 8'hBF, 8'hA4, 8'hF9);

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
